// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage RV32I core: per-stage enables/flushes, halt drain, memory-wait watchdog.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_stall,
  input  logic             redirect,
  input  logic             halt_req,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             pc_sel_redirect,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             halted,
  output logic             mem_err
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] memwait_cnt
`endif
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;

  state_t      r_state;
  logic [15:0] r_wait_cnt;
  logic [3:0]  r_drain_cnt;
  logic        r_halted;
  logic        r_mem_err;

  logic        w_mem_busy;
  logic        w_run_decode;
  logic        w_busy_run;
  logic        w_wait_stall;
  logic [16:0] w_wait_next;

  assign w_mem_busy   = dmem_req & ~dmem_ready;
  // The cycle memory completes in MEM_WAIT is decoded exactly like RUN with no memory stall.
  assign w_run_decode = (r_state == RUN) | ((r_state == MEM_WAIT) & dmem_ready);
  assign w_busy_run   = (r_state == RUN) & w_mem_busy;
  assign w_wait_stall = (r_state == MEM_WAIT) & ~dmem_ready;
  assign w_wait_next  = {1'b0, r_wait_cnt} + 17'd1;

  assign halted  = r_halted;
  assign mem_err = r_mem_err;

  always_comb begin
    pc_en           = 1'b0;
    pc_sel_redirect = 1'b0;
    if_id_en        = 1'b0;
    if_id_flush     = 1'b0;
    id_ex_en        = 1'b0;
    id_ex_flush     = 1'b0;
    ex_mem_en       = 1'b0;
    mem_wb_en       = 1'b0;
    if (rst) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (w_run_decode) begin
      if (w_busy_run) begin
        pc_en = 1'b0;
      end else if (halt_req) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
      end else if (redirect) begin
        pc_en           = 1'b1;
        pc_sel_redirect = 1'b1;
        if_id_en        = 1'b1;
        if_id_flush     = 1'b1;
        id_ex_en        = 1'b1;
        id_ex_flush     = 1'b1;
        ex_mem_en       = 1'b1;
        mem_wb_en       = 1'b1;
      end else if (hazard_stall) begin
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
      end else begin
        pc_en     = 1'b1;
        if_id_en  = 1'b1;
        id_ex_en  = 1'b1;
        ex_mem_en = 1'b1;
        mem_wb_en = 1'b1;
      end
    end else if (r_state == DRAIN) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      ex_mem_en   = ~w_mem_busy;
      mem_wb_en   = ~w_mem_busy;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_drain_cnt <= '0;
      r_halted    <= 1'b0;
      r_mem_err   <= 1'b0;
    end else begin
      case (r_state)
        RUN, MEM_WAIT: begin
          if (w_busy_run) begin
            r_wait_cnt <= 16'd1;
            r_state    <= MEM_WAIT;
          end else if (w_wait_stall) begin
            if (w_wait_next >= 17'(MEM_TIMEOUT)) begin
              r_mem_err <= 1'b1;
              r_state   <= HALTED;
            end else begin
              r_wait_cnt <= w_wait_next[15:0];
            end
          end else if (halt_req) begin
            r_drain_cnt <= 4'(DRAIN_CYCLES);
            r_state     <= DRAIN;
          end else begin
            r_state <= RUN;
          end
        end
        DRAIN: begin
          if (!w_mem_busy) begin
            if (r_drain_cnt <= 4'd1) begin
              r_drain_cnt <= '0;
              r_halted    <= 1'b1;
              r_state     <= HALTED;
            end else begin
              r_drain_cnt <= r_drain_cnt - 4'd1;
            end
          end
        end
        default: r_state <= HALTED;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic w_stall_evt;
  logic w_redirect_evt;
  logic w_memwait_evt;

  assign w_stall_evt    = w_run_decode & ~w_busy_run & ~halt_req & ~redirect & hazard_stall;
  assign w_redirect_evt = w_run_decode & ~w_busy_run & ~halt_req & redirect;
  assign w_memwait_evt  = w_busy_run | w_wait_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      memwait_cnt <= '0;
    end else begin
      if (w_stall_evt)    stall_cnt   <= stall_cnt + 1'b1;
      if (w_redirect_evt) flush_cnt   <= flush_cnt + 1'b1;
      if (w_memwait_evt)  memwait_cnt <= memwait_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random stimulus against a cycle model.
// Counter checks are active when PIPE_CTRL_PERF_EN is defined.
module tb_pipe_ctrl;
  localparam int DC = 3;
  localparam int MT = 8;
  localparam int CW = 16;

  // {pc_en, pc_sel_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en}
  localparam logic [7:0] O_RESET  = 8'b0001_0100;
  localparam logic [7:0] O_IDLE   = 8'b1010_1011;
  localparam logic [7:0] O_REDIR  = 8'b1111_1111;
  localparam logic [7:0] O_STALL  = 8'b0000_1111;
  localparam logic [7:0] O_HALT   = 8'b0001_0111;
  localparam logic [7:0] O_DRAIN  = 8'b0001_0111;
  localparam logic [7:0] O_DRAINB = 8'b0001_0100;
  localparam logic [7:0] O_FROZEN = 8'b0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, hazard_stall, redirect, halt_req, dmem_req, dmem_ready;
  logic pc_en, pc_sel_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic ex_mem_en, mem_wb_en, halted, mem_err;
`ifdef PIPE_CTRL_PERF_EN
  logic [CW-1:0] stall_cnt, flush_cnt, memwait_cnt;
`endif

  pipe_ctrl #(.DRAIN_CYCLES(DC), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .hazard_stall(hazard_stall), .redirect(redirect),
    .halt_req(halt_req), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .pc_sel_redirect(pc_sel_redirect), .if_id_en(if_id_en),
    .if_id_flush(if_id_flush), .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .halted(halted), .mem_err(mem_err)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .memwait_cnt(memwait_cnt)
`endif
  );

  wire [7:0] w_out = {pc_en, pc_sel_redirect, if_id_en, if_id_flush,
                      id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en};

  int checks = 0;
  int failures = 0;

  task automatic drive(input logic r, hs, rd, hr, dq, dr);
    @(negedge clk);
    rst = r; hazard_stall = hs; redirect = rd; halt_req = hr; dmem_req = dq; dmem_ready = dr;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 0, 0);
      checks++;
      if (w_out !== O_RESET) begin
        failures++; $display("FAIL reset_outputs got=%b want=%b", w_out, O_RESET);
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if ({w_out, halted, mem_err} !== {O_IDLE, 2'b00}) begin
      failures++; $display("FAIL post_reset_idle got=%b/%b%b want=%b/00", w_out, halted, mem_err, O_IDLE);
    end
  endtask

  task automatic test_hazard();
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 0, 0, 0);
      checks++;
      if (w_out !== O_STALL) begin
        failures++; $display("FAIL hazard_stall_%0d got=%b want=%b", i, w_out, O_STALL);
      end
    end
    drive(0, 0, 0, 0, 0, 0);
`ifdef PIPE_CTRL_PERF_EN
    checks++;
    if (stall_cnt !== CW'(2)) begin
      failures++; $display("FAIL stall_cnt got=%0d want=2", stall_cnt);
    end
`endif
  endtask

  task automatic test_redirect_over_stall();
    drive(0, 1, 1, 0, 0, 0);
    checks++;
    if (w_out !== O_REDIR) begin
      failures++; $display("FAIL redirect_vs_stall got=%b want=%b", w_out, O_REDIR);
    end
    drive(0, 0, 0, 0, 0, 0);
`ifdef PIPE_CTRL_PERF_EN
    checks++;
    if ({stall_cnt, flush_cnt} !== {CW'(2), CW'(1)}) begin
      failures++; $display("FAIL redirect_counters got=%0d/%0d want=2/1", stall_cnt, flush_cnt);
    end
`endif
  endtask

  task automatic test_memwait();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 0, 1, 0);
      checks++;
      if (w_out !== O_FROZEN) begin
        failures++; $display("FAIL memwait_frozen_%0d got=%b want=%b", i, w_out, O_FROZEN);
      end
    end
    drive(0, 0, 1, 0, 1, 1);
    checks++;
    if (w_out !== O_REDIR) begin
      failures++; $display("FAIL memwait_release_redirect got=%b want=%b", w_out, O_REDIR);
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (w_out !== O_IDLE) begin
      failures++; $display("FAIL memwait_after got=%b want=%b", w_out, O_IDLE);
    end
`ifdef PIPE_CTRL_PERF_EN
    checks++;
    if ({memwait_cnt, flush_cnt} !== {CW'(4), CW'(2)}) begin
      failures++; $display("FAIL memwait_counters got=%0d/%0d want=4/2", memwait_cnt, flush_cnt);
    end
`endif
  endtask

  task automatic test_halt_drain();
    drive(0, 0, 1, 1, 0, 0);
    checks++;
    if (w_out !== O_HALT) begin
      failures++; $display("FAIL halt_accept got=%b want=%b", w_out, O_HALT);
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if ({w_out, halted} !== {O_DRAIN, 1'b0}) begin
      failures++; $display("FAIL drain_1 got=%b/%b want=%b/0", w_out, halted, O_DRAIN);
    end
    drive(0, 0, 0, 0, 1, 0);
    checks++;
    if (w_out !== O_DRAINB) begin
      failures++; $display("FAIL drain_membusy got=%b want=%b", w_out, O_DRAINB);
    end
    drive(0, 1, 1, 0, 0, 0);
    checks++;
    if (w_out !== O_DRAIN) begin
      failures++; $display("FAIL drain_ignores_redirect got=%b want=%b", w_out, O_DRAIN);
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if ({w_out, halted} !== {O_DRAIN, 1'b0}) begin
      failures++; $display("FAIL drain_4 got=%b/%b want=%b/0", w_out, halted, O_DRAIN);
    end
    drive(0, 0, 1, 0, 0, 0);
    checks++;
    if ({w_out, halted} !== {O_FROZEN, 1'b1}) begin
      failures++; $display("FAIL halted got=%b/%b want=%b/1", w_out, halted, O_FROZEN);
    end
  endtask

  task automatic test_timeout();
    drive(1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= MT; k++) begin
      drive(0, 0, 0, 0, 1, 0);
      checks++;
      if ({w_out, mem_err} !== {O_FROZEN, 1'b0}) begin
        failures++; $display("FAIL timeout_wait_%0d got=%b/%b want=%b/0", k, w_out, mem_err, O_FROZEN);
      end
    end
    drive(0, 0, 0, 0, 1, 0);
    checks++;
    if ({w_out, mem_err} !== {O_FROZEN, 1'b1}) begin
      failures++; $display("FAIL timeout_err got=%b/%b want=%b/1", w_out, mem_err, O_FROZEN);
    end
    drive(0, 1, 1, 1, 1, 1);
    checks++;
    if ({w_out, mem_err} !== {O_FROZEN, 1'b1}) begin
      failures++; $display("FAIL halted_ignores_inputs got=%b/%b want=%b/1", w_out, mem_err, O_FROZEN);
    end
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if ({w_out, mem_err} !== {O_IDLE, 1'b0}) begin
      failures++; $display("FAIL timeout_reset_clear got=%b/%b want=%b/0", w_out, mem_err, O_IDLE);
    end
  endtask

  // Random stimulus against a model that tracks what the pipeline is doing in plain terms.
  task automatic test_random();
    int mode;          // 0 running, 1 stalled on memory, 2 draining, 3 stopped
    int waited, drain_left;
    logic m_halted, m_err;
    logic [CW-1:0] m_stall, m_flush, m_wait;
    logic [7:0] exp;
    logic r, hs, rd, hr, dq, dr, busy;
    mode = 0; waited = 0; drain_left = 0; m_halted = 0; m_err = 0;
    m_stall = '0; m_flush = '0; m_wait = '0;
    drive(1, 0, 0, 0, 0, 0);
    for (int cyc = 0; cyc < 600; cyc++) begin
      r  = ($urandom_range(0, 39) == 0);
      hs = ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 4) == 0);
      hr = ($urandom_range(0, 14) == 0);
      dq = ($urandom_range(0, 2) == 0);
      dr = (cyc % 97 > 80) ? 1'b0 : ($urandom_range(0, 1) == 0);
      busy = dq & ~dr;
      drive(r, hs, rd, hr, dq, dr);
      if (r) exp = O_RESET;
      else if ((mode == 0 && !busy) || (mode == 1 && dr)) begin
        if (hr) exp = O_HALT;
        else if (rd) exp = O_REDIR;
        else if (hs) exp = O_STALL;
        else exp = O_IDLE;
      end else if (mode == 2) exp = busy ? O_DRAINB : O_DRAIN;
      else exp = O_FROZEN;
      checks++;
      if ({w_out, halted, mem_err} !== {exp, m_halted, m_err}) begin
        failures++;
        $display("FAIL random_cycle_%0d got=%b/%b%b want=%b/%b%b", cyc, w_out, halted, mem_err, exp, m_halted, m_err);
      end
`ifdef PIPE_CTRL_PERF_EN
      checks++;
      if ({stall_cnt, flush_cnt, memwait_cnt} !== {m_stall, m_flush, m_wait}) begin
        failures++;
        $display("FAIL random_counters_%0d got=%0d/%0d/%0d want=%0d/%0d/%0d", cyc,
                 stall_cnt, flush_cnt, memwait_cnt, m_stall, m_flush, m_wait);
      end
`endif
      if (r) begin
        mode = 0; waited = 0; drain_left = 0; m_halted = 0; m_err = 0;
        m_stall = '0; m_flush = '0; m_wait = '0;
      end else if (mode == 0 && busy) begin
        mode = 1; waited = 1; m_wait++;
      end else if (mode == 1 && !dr) begin
        waited++; m_wait++;
        if (waited >= MT) begin mode = 3; m_err = 1; end
      end else if (mode == 0 || mode == 1) begin
        mode = 0;
        if (hr) begin mode = 2; drain_left = DC; end
        else if (rd) m_flush++;
        else if (hs) m_stall++;
      end else if (mode == 2 && !busy) begin
        drain_left--;
        if (drain_left == 0) begin mode = 3; m_halted = 1; end
      end
    end
  endtask

  initial begin
    rst = 1; hazard_stall = 0; redirect = 0; halt_req = 0; dmem_req = 0; dmem_ready = 0;
    test_reset();
    test_hazard();
    test_redirect_over_stall();
    test_memwait();
    test_halt_drain();
    test_timeout();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
